reg_mem_sequencer: RTL
======================

# reg_mem_sequencer

Multi-cycle command sequencer that drives the opcode and address inputs of the memory/register/security/ALU datapath top level. It accepts one transfer or ALU command at a time over a valid/ready handshake and expands it into a fixed two-phase opcode sequence. Data moves through the security stage in the datapath; this block only schedules it. The block sits between a host/test driver and the datapath top.

## Interface
Parameters:
- ADDR_W, 8, width of every memory/register address field
- OPC_W, 5, datapath opcode width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (IDLE only)
- cmd_op  in  2  0 LOAD (mem→reg), 1 STORE (reg→mem), 2 ALU, 3 NOP
- cmd_func  in  3  ALU function; ignored unless ALU
- cmd_a  in  ADDR_W  LOAD: mem src; STORE: reg src; ALU: rs1
- cmd_b  in  ADDR_W  LOAD: reg dst; STORE: mem dst; ALU: rs2
- cmd_c  in  ADDR_W  ALU: rd; otherwise ignored
- opcode  out  OPC_W  to datapath opcode
- read_address_reg, write_address_reg, reg1, reg2, address_mem, address_alu, address_to_mem  out  ADDR_W  to datapath ports of the same names
- alu_zero  in  1  datapath zero flag
- zero_flag  out  1  zero captured at end of last ALU command
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse per completed command

## Operation
- FSM states: IDLE, PH1, PH2, DONE. All outputs registered.
- IDLE: cmd_ready=1, opcode=OP_IDLE. On cmd_valid: latch command fields; NOP → DONE; else → PH1.
- LOAD: PH1 opcode=OP_MEM_TO_SEC, read_address_reg=cmd_a. PH2 opcode=OP_SEC_TO_REG, address_mem=cmd_b.
- STORE: PH1 opcode=OP_REG_TO_SEC, address_to_mem=cmd_a. PH2 opcode=OP_SEC_TO_MEM, write_address_reg=cmd_b.
- ALU: PH1 opcode=OP_ALU_RD|func, reg1=cmd_a, reg2=cmd_b. PH2 opcode=OP_ALU_WR|func, reg1/reg2 held, address_alu=cmd_c. At PH2 exit, zero_flag←alu_zero.
- PH1→PH2→DONE unconditionally. DONE: done=1, opcode=OP_IDLE, cmd_ready=1. Accepting a command in DONE goes straight to PH1 (or DONE for NOP), else → IDLE.
- Address outputs not targeted by the current phase hold their last value; zero_flag changes only on ALU completion.
- Reset (any state, any time): state=IDLE, opcode=OP_IDLE, all addresses 0, zero_flag=0, done=0, busy=0, cmd_ready=0 while rst_n low, 1 in the first cycle after release. An in-flight command is dropped and no done is produced.

## Timing
- Handshake at rising edge with cmd_valid&cmd_ready. Accept at edge k: PH1 values visible in cycle k+1, PH2 in k+2, done in k+3.
- NOP: done in cycle k+1.
- Back-to-back: cmd_ready high in the DONE cycle, so throughput is one command per 3 cycles (1 for NOP).
- cmd_* must be stable only in the accept cycle; fields are latched.

## Structure
- Package seq_pkg: OPC_W; cmd_op enum (CMD_LOAD=0, CMD_STORE=1, CMD_ALU=2, CMD_NOP=3); state enum; opcode constants OP_IDLE=5'h00, OP_MEM_TO_SEC=5'h01, OP_SEC_TO_REG=5'h02, OP_REG_TO_SEC=5'h03, OP_SEC_TO_MEM=5'h04, OP_ALU_RD=5'h10, OP_ALU_WR=5'h18. ALU opcodes are base|func. The datapath control unit's decode is aligned to these constants.
- The block is a single module with no sub-modules. A top-level wrapper instantiates it next to the datapath top.

## Test plan
- LOAD a=0x12, b=0x05 accepted at edge 0 → cycle 1: opcode 0x01, read_address_reg 0x12. Cycle 2: opcode 0x04… no, cycle 2: opcode 0x02, address_mem 0x05. Cycle 3: done=1.
- ALU func=3, a=1, b=2, c=7, alu_zero=1 during PH2 → opcodes 0x13 then 0x1B, address_alu 0x07, zero_flag=1 from cycle 3.
- STORE then LOAD with cmd_valid held high → second accept in the DONE cycle. Opcode stream 03,04,00,01,02,00. Exactly two done pulses.
- NOP → done one cycle after accept, opcode stays 0x00, no address change.
- rst_n low during PH1 of an ALU command → all outputs at reset values immediately, no done. After release: cmd_ready=1 and zero_flag=0.
- cmd_valid while busy → not accepted (cmd_ready=0), and the command is accepted only on its first ready cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and opcode constants for the register/memory command sequencer.
// The datapath control unit decodes exactly these opcode values.
package seq_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'd0,
    CMD_STORE = 2'd1,
    CMD_ALU   = 2'd2,
    CMD_NOP   = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PH1,
    ST_PH2,
    ST_DONE
  } state_e;

  localparam logic [OPC_W-1:0] OP_IDLE       = 5'h00;
  localparam logic [OPC_W-1:0] OP_MEM_TO_SEC = 5'h01;
  localparam logic [OPC_W-1:0] OP_SEC_TO_REG = 5'h02;
  localparam logic [OPC_W-1:0] OP_REG_TO_SEC = 5'h03;
  localparam logic [OPC_W-1:0] OP_SEC_TO_MEM = 5'h04;
  localparam logic [OPC_W-1:0] OP_ALU_RD     = 5'h10;
  localparam logic [OPC_W-1:0] OP_ALU_WR     = 5'h18;

  // ALU opcodes carry the function code in their low three bits.
  function automatic logic [OPC_W-1:0] alu_opc(input logic [OPC_W-1:0] base,
                                               input logic [2:0]       func);
    return base | {2'b00, func};
  endfunction

endpackage

// File: rtl/reg_mem_sequencer.sv
// Two-phase command sequencer: turns one LOAD/STORE/ALU/NOP command into the
// opcode and address schedule the memory/register/security/ALU datapath expects.
module reg_mem_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_func,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [ADDR_W-1:0] cmd_c,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] read_address_reg,
  output logic [ADDR_W-1:0] write_address_reg,
  output logic [ADDR_W-1:0] reg1,
  output logic [ADDR_W-1:0] reg2,
  output logic [ADDR_W-1:0] address_mem,
  output logic [ADDR_W-1:0] address_alu,
  output logic [ADDR_W-1:0] address_to_mem,
  input  logic              alu_zero,
  output logic              zero_flag,
  output logic              busy,
  output logic              done
);

  state_e            state;
  logic              ready_q;
  logic              accept;
  cmd_op_e           lat_op;
  logic [2:0]        lat_func;
  logic [ADDR_W-1:0] lat_b;
  logic [ADDR_W-1:0] lat_c;

  // ready_q resets high so the block is ready in the very first cycle after
  // release; gating with rst_n keeps it low while reset is held.
  assign cmd_ready = ready_q & rst_n;
  assign accept    = cmd_valid & cmd_ready;

  // Latch the command fields at accept; the PH2 targets come from here.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_op   <= cmd_op_e'(cmd_op);
      lat_func <= cmd_func;
      lat_b    <= cmd_b;
      lat_c    <= cmd_c;
    end
  end

  // Phase FSM with all outputs registered; PH1 values come straight from the
  // command inputs so they appear in the cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      ready_q           <= 1'b1;
      opcode            <= OP_IDLE;
      read_address_reg  <= '0;
      write_address_reg <= '0;
      reg1              <= '0;
      reg2              <= '0;
      address_mem       <= '0;
      address_alu       <= '0;
      address_to_mem    <= '0;
      zero_flag         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          opcode <= OP_IDLE;
          if (accept) begin
            busy <= 1'b1;
            if (cmd_op_e'(cmd_op) == CMD_NOP) begin
              state   <= ST_DONE;
              ready_q <= 1'b1;
              done    <= 1'b1;
            end else begin
              state   <= ST_PH1;
              ready_q <= 1'b0;
              case (cmd_op_e'(cmd_op))
                CMD_LOAD: begin
                  opcode           <= OP_MEM_TO_SEC;
                  read_address_reg <= cmd_a;
                end
                CMD_STORE: begin
                  opcode         <= OP_REG_TO_SEC;
                  address_to_mem <= cmd_a;
                end
                default: begin
                  opcode <= alu_opc(OP_ALU_RD, cmd_func);
                  reg1   <= cmd_a;
                  reg2   <= cmd_b;
                end
              endcase
            end
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end
        end
        ST_PH1: begin
          state <= ST_PH2;
          case (lat_op)
            CMD_LOAD: begin
              opcode      <= OP_SEC_TO_REG;
              address_mem <= lat_b;
            end
            CMD_STORE: begin
              opcode            <= OP_SEC_TO_MEM;
              write_address_reg <= lat_b;
            end
            default: begin
              opcode      <= alu_opc(OP_ALU_WR, lat_func);
              address_alu <= lat_c;
            end
          endcase
        end
        ST_PH2: begin
          state   <= ST_DONE;
          opcode  <= OP_IDLE;
          done    <= 1'b1;
          ready_q <= 1'b1;
          if (lat_op == CMD_ALU) zero_flag <= alu_zero;
        end
        default: begin
          state   <= ST_IDLE;
          opcode  <= OP_IDLE;
          ready_q <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
